tomasulo_cdb_arb: RTL and testbench

TOMASULO_CDB_ARB -- requirements
Module: tomasulo_cdb_arb

---
 rtl/tomasulo_cdb_arb.sv | 178 +++++++++++++++++
 tb/tb_tomasulo_cdb_arb.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/tomasulo_cdb_arb.sv
// Common-data-bus arbiter: per-requester holding FIFOs feeding one round-robin broadcast bus.
// Latency: a push at edge E can appear on cdb_r at edge E+1 at the earliest. No same-cycle bypass.
// Backpressure: in_rdy is registered queue-not-full per requester. cdb_r has no backpressure.
//
// Ports:
//   clk, rst        - single clock; synchronous active-low reset
//   in_vld / in     - per-requester completion strobe and payload (payload .vld is ignored)
//   in_rdy          - per-requester registered "queue has room"
//   cdb_r / gnt_r   - registered bus broadcast and its one-hot source (zero when idle)

package tomasulo_pkg;
  typedef struct packed {
    logic        vld;
    logic [5:0]  tag;
    logic [31:0] wdata;
    logic [4:0]  robid;
    logic [4:0]  wa;
  } cdb_t;
endpackage

// Generic holding FIFO: DEPTH entries, registered push-ready, head visible combinationally.
// Latency: an entry written at edge E is at the head (and poppable) from edge E onward.
// Backpressure: push_rdy_o reflects occupancy after this cycle's push/pop, registered.
// Ports: clk_i/rst_ni sync active-low reset; push_vld_i/push_dat_i/push_rdy_o write side;
//        pop_i/head_dat_o/empty_o read side (pop of an empty FIFO is ignored).
module cdb_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 2
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         push_vld_i,
  input  logic [W-1:0] push_dat_i,
  output logic         push_rdy_o,
  input  logic         pop_i,
  output logic [W-1:0] head_dat_o,
  output logic         empty_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          rdy_q, rdy_d;
  logic          push_fire, pop_fire;

  assign empty_o    = (cnt_q == '0);
  assign head_dat_o = mem_q[rd_ptr_q];
  assign push_rdy_o = rdy_q;
  // rdy_q is high exactly when cnt_q < DEPTH, so it alone guards overflow.
  assign push_fire  = push_vld_i & rdy_q;
  assign pop_fire   = pop_i & ~empty_o;

  always_comb begin
    // DEPTH is a power of two, so the natural pointer rollover is the modulo wrap.
    wr_ptr_d = wr_ptr_q + AW'(push_fire);
    rd_ptr_d = rd_ptr_q + AW'(pop_fire);
    cnt_d    = cnt_q + CW'(push_fire) - CW'(pop_fire);
    rdy_d    = (cnt_d < CW'(DEPTH));
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      rdy_q    <= 1'b1;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      rdy_q    <= rdy_d;
    end
  end

  // Storage is not reset; occupancy alone decides what is valid.
  always_ff @(posedge clk_i) begin
    if (rst_ni && push_fire) begin
      mem_q[wr_ptr_q] <= push_dat_i;
    end
  end
endmodule

module tomasulo_cdb_arb
  import tomasulo_pkg::*;
#(
  parameter int N     = 4,
  parameter int DEPTH = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N-1:0]            in_vld,
  input  tomasulo_pkg::cdb_t [N-1:0] in,
  output logic [N-1:0]            in_rdy,
  output tomasulo_pkg::cdb_t      cdb_r,
  output logic [N-1:0]            gnt_r
);
  localparam int IW = $clog2(N);
  localparam int PW = $bits(cdb_t);

  logic [PW-1:0] head_dat [N];
  logic [N-1:0]  empty;
  logic [N-1:0]  win_oh;

  // Round-robin priority pointer: the requester checked first this cycle.
  logic [IW-1:0] ptr_q, ptr_d;
  cdb_t          cdb_q, cdb_d;
  logic [N-1:0]  gnt_q, gnt_d;

  logic          win_vld;
  logic [IW-1:0] win_idx;
  logic [IW:0]   scan;

  for (genvar gi = 0; gi < N; gi++) begin : g_q
    cdb_fifo #(
      .W     (PW),
      .DEPTH (DEPTH)
    ) u_fifo (
      .clk_i      (clk),
      .rst_ni     (rst),
      .push_vld_i (in_vld[gi]),
      .push_dat_i (in[gi]),
      .push_rdy_o (in_rdy[gi]),
      .pop_i      (win_oh[gi]),
      .head_dat_o (head_dat[gi]),
      .empty_o    (empty[gi])
    );
  end

  // Scan ptr_q, ptr_q+1, ... (mod N); the first non-empty queue wins.
  always_comb begin
    win_vld = 1'b0;
    win_idx = '0;
    scan    = '0;
    for (int k = 0; k < N; k++) begin
      scan = {1'b0, ptr_q} + (IW+1)'(k);
      if (scan >= (IW+1)'(N)) begin
        scan = scan - (IW+1)'(N);
      end
      if (!win_vld && !empty[scan[IW-1:0]]) begin
        win_vld = 1'b1;
        win_idx = scan[IW-1:0];
      end
    end
  end

  always_comb begin
    win_oh = '0;
    ptr_d  = ptr_q;
    cdb_d  = '0;
    gnt_d  = '0;
    if (win_vld) begin
      win_oh    = N'(1) << win_idx;
      ptr_d     = (win_idx == IW'(N-1)) ? '0 : win_idx + 1'b1;
      cdb_d     = cdb_t'(head_dat[win_idx]);
      // The stored vld bit is whatever the requester drove; the bus asserts its own.
      cdb_d.vld = 1'b1;
      gnt_d     = win_oh;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      ptr_q <= '0;
      cdb_q <= '0;
      gnt_q <= '0;
    end else begin
      ptr_q <= ptr_d;
      cdb_q <= cdb_d;
      gnt_q <= gnt_d;
    end
  end

  assign cdb_r = cdb_q;
  assign gnt_r = gnt_q;
endmodule

// File: tb/tb_tomasulo_cdb_arb.sv
// Bench for tomasulo_cdb_arb (N=4, DEPTH=2): directed table of single-edge vectors,
// then scoreboarded sequences for alternating grants, full-queue holding, and random load.
module tb_tomasulo_cdb_arb;
  import tomasulo_pkg::*;

  localparam int N     = 4;
  localparam int DEPTH = 2;

  logic               clk = 1'b0;
  logic               rst;
  logic [N-1:0]       in_vld;
  cdb_t [N-1:0]       in_p;
  logic [N-1:0]       in_rdy;
  cdb_t               cdb_r;
  logic [N-1:0]       gnt_r;

  always #5 clk = ~clk;

  tomasulo_cdb_arb #(.N(N), .DEPTH(DEPTH)) dut (
    .clk    (clk),
    .rst    (rst),
    .in_vld (in_vld),
    .in     (in_p),
    .in_rdy (in_rdy),
    .cdb_r  (cdb_r),
    .gnt_r  (gnt_r)
  );

  int n_chk  = 0;
  int n_fail = 0;

  cdb_t sbq [N][$];
  int   occ   [N];
  int   waitc [N];
  int   nseq  [N];
  logic [N-1:0] a;

  typedef struct {
    logic        rst_n;
    logic [3:0]  vld;
    logic [5:0]  tb;
    logic [31:0] db;
    logic        ev;
    int          esrc;
    logic [5:0]  etb;
    logic [31:0] edb;
    logic [3:0]  egnt;
    logic [3:0]  erdy;
  } vec_t;

  vec_t tbl [19];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Table payload: requester i carries tag tb+i, wdata db+i.
  function automatic cdb_t mk_tbl(input logic [5:0] tb, input logic [31:0] db, input int i);
    cdb_t c;
    c.vld   = 1'b0;
    c.tag   = tb + 6'(i);
    c.wdata = db + 32'(i);
    c.robid = 5'(tb + 6'(i));
    c.wa    = 5'(i);
    return c;
  endfunction

  // Sequence payload: unique per (requester, sequence number).
  function automatic cdb_t mk_seq(input int i, input int s);
    cdb_t c;
    c.vld   = 1'b0;
    c.tag   = 6'((i << 4) | (s & 15));
    c.wdata = 32'((i << 24) | (s & 32'h00FF_FFFF));
    c.robid = 5'(s);
    c.wa    = 5'(i);
    return c;
  endfunction

  function automatic logic busy();
    logic b = 1'b0;
    for (int i = 0; i < N; i++) if (occ[i] > 0) b = 1'b1;
    return b;
  endfunction

  // One clock with scoreboard checks; acc reports which pushes the DUT accepted.
  task automatic cycle_sb(input logic [N-1:0] v, output logic [N-1:0] acc);
    int   occ_b [N];
    int   w;
    logic anyq;
    logic starve;
    cdb_t e;
    logic [N-1:0] erdy;
    anyq = 1'b0;
    for (int i = 0; i < N; i++) begin
      in_p[i]  = mk_seq(i, nseq[i]);
      occ_b[i] = occ[i];
      if (occ[i] > 0) anyq = 1'b1;
    end
    in_vld = v;
    acc    = v & in_rdy;
    @(posedge clk);
    @(negedge clk);
    chk("sb_vld", 64'(cdb_r.vld), 64'(anyq));
    chk("sb_gnt_onehot", 64'($countones(gnt_r) == (cdb_r.vld ? 1 : 0)), 64'(1));
    w = -1;
    for (int i = N - 1; i >= 0; i--) if (gnt_r[i]) w = i;
    if (w >= 0) begin
      chk("sb_gnt_nonempty", 64'(occ_b[w] > 0), 64'(1));
      if (sbq[w].size() > 0) begin
        e = sbq[w].pop_front();
        e.vld = 1'b1;
        chk("sb_order", 64'(cdb_r), 64'(e));
        occ[w]--;
      end
    end
    starve = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (i == w || occ_b[i] == 0) waitc[i] = 0;
      else if (w >= 0) begin
        waitc[i]++;
        if (waitc[i] > N - 1) starve = 1'b1;
      end
    end
    chk("sb_fair", 64'(starve), 64'(0));
    for (int i = 0; i < N; i++) begin
      if (acc[i]) begin
        sbq[i].push_back(mk_seq(i, nseq[i]));
        nseq[i]++;
        occ[i]++;
      end
      erdy[i] = (occ[i] < DEPTH);
    end
    chk("sb_in_rdy", 64'(in_rdy), 64'(erdy));
  endtask

  task automatic do_reset();
    rst    = 1'b0;
    in_vld = '1;
    for (int i = 0; i < N; i++) in_p[i] = mk_seq(i, nseq[i]);
    @(posedge clk);
    @(negedge clk);
    rst    = 1'b1;
    in_vld = '0;
    chk("rst_cdb", 64'(cdb_r), 64'(0));
    chk("rst_gnt", 64'(gnt_r), 64'(0));
    chk("rst_rdy", 64'(in_rdy), 64'(4'b1111));
    for (int i = 0; i < N; i++) begin
      sbq[i].delete();
      occ[i]   = 0;
      waitc[i] = 0;
    end
  endtask

  task automatic drain(input string name);
    logic [N-1:0] da;
    int tot;
    for (int k = 0; k < 4 * N * DEPTH && busy(); k++) cycle_sb('0, da);
    tot = 0;
    for (int i = 0; i < N; i++) tot += occ[i] + sbq[i].size();
    chk(name, 64'(tot), 64'(0));
  endtask

  initial begin
    #10_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    cdb_t         exp_c;
    logic [3:0]   acc1;
    int           pushed1;

    rst    = 1'b0;
    in_vld = '0;
    in_p   = '0;
    for (int i = 0; i < N; i++) begin
      occ[i] = 0; waitc[i] = 0; nseq[i] = 0;
    end

    //            rst vld      tb     db          ev src etb    edb         egnt     erdy
    tbl[0]  = '{1'b0, 4'b1111, 6'h00, 32'h0000, 1'b0, 0, 6'h00, 32'h0000, 4'b0000, 4'b1111};
    tbl[1]  = '{1'b0, 4'b1111, 6'h00, 32'h0000, 1'b0, 0, 6'h00, 32'h0000, 4'b0000, 4'b1111};
    tbl[2]  = '{1'b1, 4'b0100, 6'h03, 32'h1232, 1'b0, 0, 6'h00, 32'h0000, 4'b0000, 4'b1111};
    tbl[3]  = '{1'b1, 4'b0000, 6'h00, 32'h0000, 1'b1, 2, 6'h03, 32'h1232, 4'b0100, 4'b1111};
    tbl[4]  = '{1'b1, 4'b0000, 6'h00, 32'h0000, 1'b0, 0, 6'h00, 32'h0000, 4'b0000, 4'b1111};
    tbl[5]  = '{1'b1, 4'b1000, 6'h10, 32'h0100, 1'b0, 0, 6'h00, 32'h0000, 4'b0000, 4'b1111};
    tbl[6]  = '{1'b1, 4'b0000, 6'h00, 32'h0000, 1'b1, 3, 6'h10, 32'h0100, 4'b1000, 4'b1111};
    tbl[7]  = '{1'b1, 4'b1111, 6'h20, 32'h2000, 1'b0, 0, 6'h00, 32'h0000, 4'b0000, 4'b1111};
    tbl[8]  = '{1'b1, 4'b0000, 6'h00, 32'h0000, 1'b1, 0, 6'h20, 32'h2000, 4'b0001, 4'b1111};
    tbl[9]  = '{1'b1, 4'b0000, 6'h00, 32'h0000, 1'b1, 1, 6'h20, 32'h2000, 4'b0010, 4'b1111};
    tbl[10] = '{1'b1, 4'b0000, 6'h00, 32'h0000, 1'b1, 2, 6'h20, 32'h2000, 4'b0100, 4'b1111};
    tbl[11] = '{1'b1, 4'b0000, 6'h00, 32'h0000, 1'b1, 3, 6'h20, 32'h2000, 4'b1000, 4'b1111};
    tbl[12] = '{1'b1, 4'b0000, 6'h00, 32'h0000, 1'b0, 0, 6'h00, 32'h0000, 4'b0000, 4'b1111};
    tbl[13] = '{1'b1, 4'b1111, 6'h30, 32'h3000, 1'b0, 0, 6'h00, 32'h0000, 4'b0000, 4'b1111};
    tbl[14] = '{1'b1, 4'b1111, 6'h38, 32'h3800, 1'b1, 0, 6'h30, 32'h3000, 4'b0001, 4'b0001};
    tbl[15] = '{1'b1, 4'b0001, 6'h3C, 32'h3C00, 1'b1, 1, 6'h30, 32'h3000, 4'b0010, 4'b0010};
    tbl[16] = '{1'b0, 4'b1111, 6'h00, 32'h0000, 1'b0, 0, 6'h00, 32'h0000, 4'b0000, 4'b1111};
    tbl[17] = '{1'b1, 4'b0000, 6'h00, 32'h0000, 1'b0, 0, 6'h00, 32'h0000, 4'b0000, 4'b1111};
    tbl[18] = '{1'b1, 4'b0000, 6'h00, 32'h0000, 1'b0, 0, 6'h00, 32'h0000, 4'b0000, 4'b1111};

    for (int r = 0; r < 19; r++) begin
      rst    = tbl[r].rst_n;
      in_vld = tbl[r].vld;
      for (int i = 0; i < N; i++) in_p[i] = mk_tbl(tbl[r].tb, tbl[r].db, i);
      @(posedge clk);
      @(negedge clk);
      exp_c = '0;
      if (tbl[r].ev) begin
        exp_c     = mk_tbl(tbl[r].etb, tbl[r].edb, tbl[r].esrc);
        exp_c.vld = 1'b1;
      end
      chk($sformatf("row%0d_cdb", r), 64'(cdb_r), 64'(exp_c));
      chk($sformatf("row%0d_gnt", r), 64'(gnt_r), 64'(tbl[r].egnt));
      chk($sformatf("row%0d_rdy", r), 64'(in_rdy), 64'(tbl[r].erdy));
    end
    in_vld = '0;

    // Requesters 0 and 3 each push every other cycle: grants alternate, queues never fill.
    do_reset();
    for (int k = 0; k < 24; k++) begin
      cycle_sb((k % 2 == 0) ? 4'b1001 : 4'b0000, a);
      chk("alt_rdy", 64'({in_rdy[3], in_rdy[0]}), 64'(2'b11));
      if (k >= 1) chk("alt_gnt", 64'(gnt_r), 64'((k % 2 == 1) ? 4'b0001 : 4'b1000));
    end
    drain("alt_drain");

    // Requester 1 pushes 3 entries while requester 0 keeps pushing: the third is held.
    do_reset();
    pushed1 = 0;
    acc1    = '0;
    for (int k = 0; k < 4; k++) begin
      cycle_sb({2'b00, (pushed1 < 3), 1'b1}, a);
      acc1[k] = a[1];
      if (a[1]) pushed1++;
      if (k == 1) chk("hold_rdy1_drop", 64'(in_rdy[1]), 64'(0));
    end
    chk("hold_acc_pattern", 64'(acc1), 64'(4'b1011));
    for (int k = 0; k < 6; k++) cycle_sb({2'b00, (pushed1 < 3), 1'b1}, a);
    drain("hold_drain");

    // Random load with periodic mid-traffic resets.
    do_reset();
    for (int c = 0; c < 10000; c++) begin
      if (c > 0 && c % 2500 == 0) do_reset();
      else cycle_sb(4'($urandom), a);
    end
    drain("rand_drain");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
